// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the request/grant arbiter
//
// Purpose: FSM state encoding and arbitration-mode constants used by
// req_grant_arbiter. No ports; imported with arb_pkg::*.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic MODE_FIXED = 1'b0;  // index 0 always highest priority
  localparam logic MODE_RR    = 1'b1;  // search starts at the rotating pointer

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-base first-one finder
//
// Purpose: starting at index `base` and wrapping modulo N, find the first set
// bit of `req`. A base of 0 gives plain lowest-index-wins priority.
// Ports:
//   req     in  [N-1:0]  request vector
//   base    in  [W-1:0]  index where the search starts (must be < N)
//   gnt_oh  out [N-1:0]  one-hot winner, all-zero when nothing requested
//   gnt_idx out [W-1:0]  binary index of winner, 0 when nothing requested
//   any     out          at least one request bit is set
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [N-1:0] rot;    // req rotated so that bit 0 corresponds to `base`
  logic [W-1:0] offset; // distance of the winner from `base`
  logic         found;
  logic [W:0]   sum;    // one extra bit so base+offset cannot overflow before the wrap

  always_comb begin
    rot    = N'({req, req} >> base);
    found  = 1'b0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        offset = W'(i);
      end
    end

    // Modulo-N wrap done by a single conditional subtract: base < N and
    // offset < N, so the sum is always below 2N.
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end

    any     = found;
    gnt_idx = found ? sum[W-1:0] : '0;
    gnt_oh  = found ? ({{(N-1){1'b0}}, 1'b1} << sum[W-1:0]) : '0;
  end

endmodule

// File: rtl/req_grant_arbiter.sv
// rtl/req_grant_arbiter.sv - fixed-priority / round-robin grant arbiter with hold budget
//
// Purpose: shares one downstream resource among NUM_REQ requesters. A grant
// is held until the owner asserts done, drops its request, or has held it for
// HOLD_MAX cycles. Every grant is followed by a one-cycle dead time.
// Ports:
//   clk       in                 rising-edge clock
//   rst_n     in                 asynchronous active-low reset
//   req       in  [NUM_REQ-1:0]  per-requester request level
//   mode      in                 0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   done      in                 current owner finished (used only while granted)
//   gnt       out [NUM_REQ-1:0]  one-hot grant
//   gnt_valid out                a grant is active
//   gnt_id    out [IDW-1:0]      index of the owner, 0 when idle
//   timeout   out                one-cycle pulse on a forced release
module req_grant_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 15,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int CW      = $clog2(HOLD_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               timeout
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      hold_cnt_q, hold_cnt_d;

  logic [IDW-1:0]     search_base;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  logic               owner_req;
  logic               hit_limit;
  logic [IDW-1:0]     next_ptr;

  // Fixed priority is the same search anchored at index 0.
  always_comb begin
    case (mode)
      MODE_FIXED: search_base = '0;
      MODE_RR:    search_base = rr_ptr_q;
      default:    search_base = '0;
    endcase
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (IDW)
  ) u_pick (
    .req     (req),
    .base    (search_base),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    // Owner's request seen through the one-hot grant, so no index decode is needed.
    owner_req = |(req & gnt_q);
    hit_limit = (hold_cnt_q == CW'(HOLD_MAX - 1));
    next_ptr  = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_d       = pick_oh;
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_idx;
          hold_cnt_d  = '0;
        end
      end

      GRANT: begin
        if (done || !owner_req || hit_limit) begin
          state_d     = RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          hold_cnt_d  = '0;
          // A voluntary release on the last budget cycle is not a timeout.
          timeout_d   = hit_limit && !done && owner_req;
          // Advanced in both modes so a later switch to round-robin stays fair.
          rr_ptr_d    = next_ptr;
        end else begin
          hold_cnt_d  = hold_cnt_q + CW'(1);
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// tb/tb_req_grant_arbiter.sv - directed self-checking bench for req_grant_arbiter
module tb_req_grant_arbiter;

  logic       clk;
  logic       rst_n;

  logic [3:0] req;
  logic       mode;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  logic [2:0] req3;
  logic       mode3;
  logic       done3;
  logic [2:0] gnt3;
  logic       gnt_valid3;
  logic [1:0] gnt_id3;
  logic       timeout3;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  req_grant_arbiter #(.NUM_REQ(4), .HOLD_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  req_grant_arbiter #(.NUM_REQ(3), .HOLD_MAX(15)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req3),
    .mode      (mode3),
    .done      (done3),
    .gnt       (gnt3),
    .gnt_valid (gnt_valid3),
    .gnt_id    (gnt_id3),
    .timeout   (timeout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

  // Ends a grant on dut (done + request drop) and waits through RELEASE into IDLE.
  task automatic release_grant();
    done = 1'b1;
    req  = 4'b0000;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 4'b1111;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", gnt_valid); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", gnt_id); else pass_cnt++;
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_held_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (gnt3 !== 3'b000) $display("FAIL reset_gnt3: got %b want 000", gnt3); else pass_cnt++;
    req   = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL idle_no_req: got %b want 0", gnt_valid); else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    mode = 1'b0;
    req  = 4'b1010;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0010) $display("FAIL fixed_gnt1: got %b want 0010", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd1) $display("FAIL fixed_id1: got %0d want 1", gnt_id); else pass_cnt++;
    chk_cnt++; if (gnt_valid !== 1'b1) $display("FAIL fixed_valid1: got %b want 1", gnt_valid); else pass_cnt++;
    done = 1'b1;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL fixed_release_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd0) $display("FAIL fixed_release_id: got %0d want 0", gnt_id); else pass_cnt++;
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL fixed_release_timeout: got %b want 0", timeout); else pass_cnt++;
    done = 1'b0;
    req  = 4'b1000;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL fixed_dead_gnt: got %b want 0000", gnt); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b1000) $display("FAIL fixed_gnt2: got %b want 1000", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd3) $display("FAIL fixed_id2: got %0d want 3", gnt_id); else pass_cnt++;
    release_grant();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    logic [3:0] want;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1'b1;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      want = 4'b0001 << order[k];
      @(negedge clk);
      chk_cnt++; if (gnt !== want) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, want); else pass_cnt++;
      chk_cnt++; if (gnt_id !== order[k]) $display("FAIL rr_id[%0d]: got %0d want %0d", k, gnt_id, order[k]); else pass_cnt++;
      done = 1'b1;
      @(negedge clk);
      chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL rr_release[%0d]: got %b want 0", k, gnt_valid); else pass_cnt++;
      done = 1'b0;
      @(negedge clk);
      chk_cnt++; if (gnt !== 4'b0000) $display("FAIL rr_idle[%0d]: got %b want 0000", k, gnt); else pass_cnt++;
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    int cnt;
    mode = 1'b0;
    req  = 4'b0100;
    @(negedge clk);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_early_pulse: got %b want 0", timeout); else pass_cnt++;
    cnt = 0;
    while (gnt === 4'b0100 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk_cnt++; if (cnt !== 15) $display("FAIL to_hold_len: got %0d want 15", cnt); else pass_cnt++;
    chk_cnt++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else pass_cnt++;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL to_gnt_drop: got %b want 0000", gnt); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", timeout); else pass_cnt++;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL to_dead_gnt: got %b want 0000", gnt); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0100) $display("FAIL to_regrant: got %b want 0100", gnt); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL drop_release_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL drop_release_timeout: got %b want 0", timeout); else pass_cnt++;
    @(negedge clk);
  endtask

  // rr_ptr is 3 here: the last owner was requester 2.
  task automatic test_simultaneous_release();
    mode = 1'b1;
    req  = 4'b1111;
    @(negedge clk);
    chk_cnt++; if (gnt_id !== 2'd3) $display("FAIL sim_first_id: got %0d want 3", gnt_id); else pass_cnt++;
    done = 1'b1;
    req  = 4'b0111;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL sim_release_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL sim_timeout: got %b want 0", timeout); else pass_cnt++;
    done = 1'b0;
    @(negedge clk);
    chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL sim_dead: got %b want 0", gnt_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0001) $display("FAIL sim_next_gnt: got %b want 0001", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd0) $display("FAIL sim_next_id: got %0d want 0", gnt_id); else pass_cnt++;
    release_grant();
  endtask

  task automatic test_npot_wrap();
    mode3 = 1'b1;
    req3  = 3'b100;
    @(negedge clk);
    chk_cnt++; if (gnt3 !== 3'b100) $display("FAIL wrap_first_gnt: got %b want 100", gnt3); else pass_cnt++;
    chk_cnt++; if (gnt_id3 !== 2'd2) $display("FAIL wrap_first_id: got %0d want 2", gnt_id3); else pass_cnt++;
    done3 = 1'b1;
    req3  = 3'b101;
    @(negedge clk);
    chk_cnt++; if (gnt3 !== 3'b000) $display("FAIL wrap_release: got %b want 000", gnt3); else pass_cnt++;
    done3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (gnt3 !== 3'b001) $display("FAIL wrap_next_gnt: got %b want 001", gnt3); else pass_cnt++;
    chk_cnt++; if (gnt_id3 !== 2'd0) $display("FAIL wrap_next_id: got %0d want 0", gnt_id3); else pass_cnt++;
    done3 = 1'b1;
    req3  = 3'b000;
    @(negedge clk);
    done3 = 1'b0;
    @(negedge clk);
  endtask

  // rr_ptr is 1 here, so round-robin with req=0100 grants 2.
  task automatic test_async_reset();
    mode = 1'b1;
    req  = 4'b0100;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0100) $display("FAIL ar_pre_gnt: got %b want 0100", gnt); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL ar_gnt: got %b want 0000", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", gnt_valid); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd0) $display("FAIL ar_id: got %0d want 0", gnt_id); else pass_cnt++;
    req = 4'b1111;
    @(negedge clk);
    chk_cnt++; if (gnt_valid !== 1'b0) $display("FAIL ar_held: got %b want 0", gnt_valid); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (gnt !== 4'b0001) $display("FAIL ar_ptr_gnt: got %b want 0001", gnt); else pass_cnt++;
    chk_cnt++; if (gnt_id !== 2'd0) $display("FAIL ar_ptr_id: got %0d want 0", gnt_id); else pass_cnt++;
    release_grant();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    done  = 1'b0;
    req3  = 3'b000;
    mode3 = 1'b0;
    done3 = 1'b0;

    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_simultaneous_release();
    test_npot_wrap();
    test_async_reset();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
